// File: rtl/ucode_loader.sv
// ucode_loader: serial boot loader that parses framed bytes into uCode writes,
// answers each frame with ACK/NAK and starts the CPU on a RUN command.
module ucode_loader #(
    parameter int unsigned CLK_FREQ     = 48_000_000,
    parameter int unsigned DATA_SZ      = 16,
    parameter int unsigned ADDR_SZ      = 10,
    parameter int unsigned TIMEOUT_CLKS = CLK_FREQ / 100
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx_wr,
    input  logic [7:0]         i_rx_data,
    input  logic               i_tx_busy,
    output logic               o_tx_wr,
    output logic [7:0]         o_tx_data,
    output logic               o_wr,
    output logic [ADDR_SZ-1:0] o_waddr,
    output logic [DATA_SZ-1:0] o_wdata,
    output logic               o_run
);

    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [7:0] SYNC_WRITE = 8'hA5;
    localparam logic [7:0] SYNC_RUN   = 8'h5A;
    localparam logic [7:0] BYTE_ACK   = 8'h06;
    localparam logic [7:0] BYTE_NAK   = 8'h15;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR_HI = 3'd1;
    localparam logic [2:0] S_ADDR_LO = 3'd2;
    localparam logic [2:0] S_COUNT   = 3'd3;
    localparam logic [2:0] S_DATA_HI = 3'd4;
    localparam logic [2:0] S_DATA_LO = 3'd5;
    localparam logic [2:0] S_CHKSUM  = 3'd6;
    localparam logic [2:0] S_REPLY   = 3'd7;

    logic [2:0]         state, state_n;
    logic [7:0]         addr_hi, addr_hi_n;
    logic [ADDR_SZ-1:0] addr, addr_n;
    logic [8:0]         count, count_n;
    logic [7:0]         data_hi, data_hi_n;
    logic [7:0]         sum, sum_n;
    logic               addr_err, addr_err_n;
    logic               reply_ack, reply_ack_n;
    logic               reply_run, reply_run_n;
    logic [TW-1:0]      tcnt, tcnt_n;

    logic               tx_wr_n;
    logic [7:0]         tx_data_n;
    logic               wr_n;
    logic [ADDR_SZ-1:0] waddr_n;
    logic [DATA_SZ-1:0] wdata_n;
    logic               run_n;

    logic [15:0]        addr16;
    logic [7:0]         sum_add;
    logic               in_frame;

    assign addr16   = {addr_hi, i_rx_data};
    assign sum_add  = sum + i_rx_data;
    assign in_frame = (state != S_IDLE) && (state != S_REPLY);

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            addr_hi   <= '0;
            addr      <= '0;
            count     <= '0;
            data_hi   <= '0;
            sum       <= '0;
            addr_err  <= 1'b0;
            reply_ack <= 1'b0;
            reply_run <= 1'b0;
            tcnt      <= '0;
            o_tx_wr   <= 1'b0;
            o_tx_data <= '0;
            o_wr      <= 1'b0;
            o_waddr   <= '0;
            o_wdata   <= '0;
            o_run     <= 1'b0;
        end else begin
            state     <= state_n;
            addr_hi   <= addr_hi_n;
            addr      <= addr_n;
            count     <= count_n;
            data_hi   <= data_hi_n;
            sum       <= sum_n;
            addr_err  <= addr_err_n;
            reply_ack <= reply_ack_n;
            reply_run <= reply_run_n;
            tcnt      <= tcnt_n;
            o_tx_wr   <= tx_wr_n;
            o_tx_data <= tx_data_n;
            o_wr      <= wr_n;
            o_waddr   <= waddr_n;
            o_wdata   <= wdata_n;
            o_run     <= run_n;
        end
    end

    // Frame parser: next state, datapath updates and next output values
    always_comb begin
        state_n     = state;
        addr_hi_n   = addr_hi;
        addr_n      = addr;
        count_n     = count;
        data_hi_n   = data_hi;
        sum_n       = sum;
        addr_err_n  = addr_err;
        reply_ack_n = reply_ack;
        reply_run_n = reply_run;
        tcnt_n      = '0;
        tx_wr_n     = 1'b0;
        tx_data_n   = o_tx_data;
        wr_n        = 1'b0;
        waddr_n     = o_waddr;
        wdata_n     = o_wdata;
        run_n       = o_run;

        case (state)
            S_IDLE: begin
                // Once running, the loader is deaf until reset
                if (i_rx_wr && !o_run) begin
                    if (i_rx_data == SYNC_WRITE) begin
                        state_n    = S_ADDR_HI;
                        sum_n      = '0;
                        addr_err_n = 1'b0;
                    end else if (i_rx_data == SYNC_RUN) begin
                        state_n     = S_REPLY;
                        reply_ack_n = 1'b1;
                        reply_run_n = 1'b1;
                    end
                end
            end
            S_ADDR_HI: begin
                if (i_rx_wr) begin
                    addr_hi_n = i_rx_data;
                    sum_n     = sum_add;
                    state_n   = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (i_rx_wr) begin
                    addr_n     = addr16[ADDR_SZ-1:0];
                    addr_err_n = (addr16 >> ADDR_SZ) != 16'd0;
                    sum_n      = sum_add;
                    state_n    = S_COUNT;
                end
            end
            S_COUNT: begin
                if (i_rx_wr) begin
                    count_n = (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
                    sum_n   = sum_add;
                    state_n = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (i_rx_wr) begin
                    data_hi_n = i_rx_data;
                    sum_n     = sum_add;
                    state_n   = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (i_rx_wr) begin
                    // Out-of-range frames are consumed without touching memory
                    if (!addr_err) begin
                        wr_n    = 1'b1;
                        waddr_n = addr;
                        wdata_n = DATA_SZ'({data_hi, i_rx_data});
                    end
                    addr_n  = addr + ADDR_SZ'(1);
                    count_n = count - 9'd1;
                    sum_n   = sum_add;
                    state_n = (count == 9'd1) ? S_CHKSUM : S_DATA_HI;
                end
            end
            S_CHKSUM: begin
                if (i_rx_wr) begin
                    sum_n       = sum_add;
                    reply_ack_n = (sum_add == 8'd0) && !addr_err;
                    reply_run_n = 1'b0;
                    state_n     = S_REPLY;
                end
            end
            S_REPLY: begin
                if (!i_tx_busy) begin
                    tx_wr_n   = 1'b1;
                    tx_data_n = reply_ack ? BYTE_ACK : BYTE_NAK;
                    if (reply_run) begin
                        run_n = 1'b1;
                    end
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Inter-byte silence inside a frame abandons it without a reply
        if (in_frame && !i_rx_wr) begin
            if (tcnt == TW'(TIMEOUT_CLKS - 1)) begin
                state_n = S_IDLE;
            end else begin
                tcnt_n = tcnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ucode_loader.sv
// Bench for ucode_loader: randomized frames checked against a frame-level model.
module tb_ucode_loader;

    localparam int unsigned ADDR_SZ = 10;
    localparam int unsigned DATA_SZ = 16;
    localparam int unsigned TO      = 200;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               rx_wr;
    logic [7:0]         rx_data;
    logic               tx_busy;
    logic               tx_wr;
    logic [7:0]         tx_data;
    logic               wr;
    logic [ADDR_SZ-1:0] waddr;
    logic [DATA_SZ-1:0] wdata;
    logic               run;

    ucode_loader #(
        .CLK_FREQ    (48_000_000),
        .DATA_SZ     (DATA_SZ),
        .ADDR_SZ     (ADDR_SZ),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_rx_wr  (rx_wr),
        .i_rx_data(rx_data),
        .i_tx_busy(tx_busy),
        .o_tx_wr  (tx_wr),
        .o_tx_data(tx_data),
        .o_wr     (wr),
        .o_waddr  (waddr),
        .o_wdata  (wdata),
        .o_run    (run)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    wr_t wr_q[$];
    int  tx_q[$];
    int  tx_c[$];
    int  overlap = 0;
    int  run_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write and reply strobe with the cycle it was seen in
    always @(negedge clk) begin
        if (wr) wr_q.push_back('{int'(waddr), int'(wdata), cyc});
        if (tx_wr) begin
            tx_q.push_back(int'(tx_data));
            tx_c.push_back(cyc);
        end
        if (wr && tx_wr) overlap++;
        if (run && run_cyc < 0) run_cyc = cyc;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        wr_q.delete();
        tx_q.delete();
        tx_c.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output int stamp);
        rx_wr   = 1'b1;
        rx_data = b;
        stamp   = cyc;
        @(negedge clk);
        rx_wr   = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic send_bytes(input bq_t fr);
        int s;
        foreach (fr[i]) begin
            send_byte(fr[i], s);
            idle($urandom_range(0, 2));
        end
    endtask

    // Random write frame; bad frames get a checksum one off from correct
    task automatic build_frame(input int addr, input int n, input bit good, output bq_t fr);
        logic [7:0] s;
        fr = '{};
        fr.push_back(8'hA5);
        fr.push_back(8'(addr >> 8));
        fr.push_back(8'(addr));
        fr.push_back(8'(n));
        for (int k = 0; k < 2 * n; k++) fr.push_back(8'($urandom));
        s = 8'd0;
        for (int i = 1; i < fr.size(); i++) s = s + fr[i];
        fr.push_back(good ? 8'(-s) : 8'(8'd1 - s));
    endtask

    // Send a write frame and compare writes, their timing and the reply with the model
    task automatic test_write_frame(input bq_t fr, input string tag);
        int st[$];
        int s;
        wr_t exp[$];
        int addr, n, exp_tx, m;
        bit err;
        logic [7:0] sum;
        clear_obs();
        foreach (fr[i]) begin
            send_byte(fr[i], s);
            st.push_back(s);
            idle($urandom_range(0, 2));
        end
        idle(8);
        addr = (int'(fr[1]) << 8) | int'(fr[2]);
        n    = (fr[3] == 8'd0) ? 256 : int'(fr[3]);
        err  = addr >= (1 << ADDR_SZ);
        sum  = 8'd0;
        for (int i = 1; i < fr.size(); i++) sum = sum + fr[i];
        exp_tx = (sum == 8'd0 && !err) ? 'h06 : 'h15;
        if (!err)
            for (int k = 0; k < n; k++)
                exp.push_back('{(addr + k) % (1 << ADDR_SZ),
                                (int'(fr[4 + 2 * k]) << 8) | int'(fr[5 + 2 * k]),
                                st[5 + 2 * k] + 1});
        total++;
        if (wr_q.size() !== exp.size()) begin
            bad++;
            $display("FAIL %s wr_count got=%0d exp=%0d", tag, wr_q.size(), exp.size());
        end
        m = (wr_q.size() < exp.size()) ? wr_q.size() : exp.size();
        for (int k = 0; k < m; k++) begin
            total++;
            if (wr_q[k].a !== exp[k].a || wr_q[k].d !== exp[k].d || wr_q[k].c !== exp[k].c) begin
                bad++;
                $display("FAIL %s write[%0d] got a=%h d=%h c=%0d exp a=%h d=%h c=%0d", tag, k,
                         wr_q[k].a, wr_q[k].d, wr_q[k].c, exp[k].a, exp[k].d, exp[k].c);
            end
        end
        total++;
        if (tx_q.size() !== 1) begin
            bad++;
            $display("FAIL %s reply_count got=%0d exp=1", tag, tx_q.size());
        end else begin
            total++;
            if (tx_q[0] !== exp_tx) begin
                bad++;
                $display("FAIL %s reply got=%h exp=%h", tag, tx_q[0], exp_tx);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        total++;
        if ({wr, tx_wr, run} !== 3'b000) begin
            bad++;
            $display("FAIL reset_strobes got=%b exp=000", {wr, tx_wr, run});
        end
        total++;
        if (tx_data !== 8'h00 || waddr !== '0 || wdata !== '0) begin
            bad++;
            $display("FAIL reset_buses got tx=%h a=%h d=%h exp 0", tx_data, waddr, wdata);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_spec_frames();
        bq_t f;
        f = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h12, 8'h34, 8'hA9};
        test_write_frame(f, "basic_ack");
        f = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h12, 8'h34, 8'hAA};
        test_write_frame(f, "bad_chk");
        f = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFB};
        test_write_frame(f, "addr_err");
        // 03+FF+02+AA+AA+55+55 = 0x302, so FE balances the frame
        f = '{8'hA5, 8'h03, 8'hFF, 8'h02, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'hFE};
        test_write_frame(f, "wrap");
    endtask

    task automatic test_random_frames();
        bq_t f;
        int a;
        build_frame(16'h0380, 256, 1'b1, f);
        test_write_frame(f, "count256");
        for (int i = 0; i < 10; i++) begin
            a = ($urandom_range(0, 4) == 0) ? $urandom_range(1024, 65535) : $urandom_range(0, 1023);
            build_frame(a, $urandom_range(1, 6), $urandom_range(0, 3) != 0, f);
            test_write_frame(f, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_timeout();
        bq_t f;
        int s;
        clear_obs();
        f = '{8'hA5, 8'h00};
        send_bytes(f);
        idle(TO + 20);
        total++;
        if (tx_q.size() !== 0 || wr_q.size() !== 0) begin
            bad++;
            $display("FAIL timeout_silent got tx=%0d wr=%0d exp 0 0", tx_q.size(), wr_q.size());
        end
        f = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h12, 8'h34, 8'hA9};
        test_write_frame(f, "after_timeout");
        // A gap just short of the limit must keep the frame alive
        clear_obs();
        f = '{8'hA5, 8'h01, 8'h23, 8'h01, 8'hBE, 8'hEF, 8'h00};
        f[6] = 8'(-(f[1] + f[2] + f[3] + f[4] + f[5]));
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], s);
            if (i == 2) idle(TO - 10);
        end
        idle(8);
        total++;
        if (wr_q.size() !== 1 || tx_q.size() !== 1) begin
            bad++;
            $display("FAIL long_gap got wr=%0d tx=%0d exp 1 1", wr_q.size(), tx_q.size());
        end else begin
            total++;
            if (wr_q[0].a !== 'h123 || wr_q[0].d !== 'hBEEF || tx_q[0] !== 'h06) begin
                bad++;
                $display("FAIL long_gap_data got a=%h d=%h tx=%h exp 123 beef 06",
                         wr_q[0].a, wr_q[0].d, tx_q[0]);
            end
        end
    endtask

    task automatic test_busy_reply();
        bq_t f;
        clear_obs();
        tx_busy = 1'b1;
        f = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h12, 8'h34, 8'hA9};
        send_bytes(f);
        idle(100);
        total++;
        if (tx_q.size() !== 0) begin
            bad++;
            $display("FAIL busy_hold got tx=%0d exp 0", tx_q.size());
        end
        tx_busy = 1'b0;
        idle(10);
        total++;
        if (tx_q.size() !== 1) begin
            bad++;
            $display("FAIL busy_release got tx=%0d exp 1", tx_q.size());
        end else begin
            total++;
            if (tx_q[0] !== 'h06) begin
                bad++;
                $display("FAIL busy_reply got=%h exp=06", tx_q[0]);
            end
        end
    endtask

    task automatic test_run();
        bq_t f;
        int s;
        clear_obs();
        run_cyc = -1;
        send_byte(8'h5A, s);
        idle(6);
        total++;
        if (tx_q.size() !== 1 || run !== 1'b1) begin
            bad++;
            $display("FAIL run_ack got tx=%0d run=%b exp 1 1", tx_q.size(), run);
        end else begin
            total++;
            if (tx_q[0] !== 'h06 || run_cyc !== tx_c[0]) begin
                bad++;
                $display("FAIL run_timing got reply=%h run_cyc=%0d exp 06 %0d",
                         tx_q[0], run_cyc, tx_c[0]);
            end
        end
        clear_obs();
        f = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h12, 8'h34, 8'hA9};
        send_bytes(f);
        idle(10);
        total++;
        if (wr_q.size() !== 0 || tx_q.size() !== 0 || run !== 1'b1) begin
            bad++;
            $display("FAIL run_ignore got wr=%0d tx=%0d run=%b exp 0 0 1",
                     wr_q.size(), tx_q.size(), run);
        end
    endtask

    task automatic test_reset_midframe();
        bq_t f;
        clear_obs();
        f = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h12};
        send_bytes(f);
        rst = 1'b1;
        idle(1);
        total++;
        if ({wr, tx_wr, run} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset got=%b exp=000", {wr, tx_wr, run});
        end
        rst = 1'b0;
        idle(2);
        // Reset while a reply is pending must cancel it
        tx_busy = 1'b1;
        f = '{8'hA5, 8'h00, 8'h20, 8'h01, 8'h12, 8'h34, 8'h99};
        send_bytes(f);
        idle(3);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        tx_busy = 1'b0;
        idle(10);
        total++;
        if (tx_q.size() !== 0) begin
            bad++;
            $display("FAIL reply_cancel got tx=%0d exp 0", tx_q.size());
        end
        f = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'h00};
        f[6] = 8'(-(f[1] + f[2] + f[3] + f[4] + f[5]));
        test_write_frame(f, "after_reset");
    endtask

    initial begin
        rst     = 1'b1;
        rx_wr   = 1'b0;
        rx_data = 8'h00;
        tx_busy = 1'b0;
        @(negedge clk);
        test_reset();
        test_spec_frames();
        test_random_frames();
        test_timeout();
        test_busy_reply();
        test_run();
        test_reset_midframe();
        total++;
        if (overlap !== 0) begin
            bad++;
            $display("FAIL wr_tx_overlap got=%0d exp=0", overlap);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
